// File: rtl/and2_arb_pkg.sv
// Shared types and constants for the round-robin and2 arbiter slice.
// Default parameter values live here so the top and the bench agree on them.
package and2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } arb_state_e;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_DATA_W   = 1;
    localparam int DEF_UNIT_LAT = 1;

    // Index width for n items; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/and2_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr,
// wrapping explicitly at NUM_REQ so non-power-of-two sizes stay in range.
module and2_rr_pick
    import and2_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    winner,
    output logic               any
);

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                                 input int unsigned    off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return sum[ID_W-1:0];
    endfunction

    // Scan from the farthest offset back to ptr so the closest requester wins.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[wrap_idx(ptr, k)]) begin
                winner = wrap_idx(ptr, k);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/and2_arbiter.sv
// Round-robin controller sharing one registered and2 unit between NUM_REQ
// requesters; results return on one valid/ready channel tagged with the id.
module and2_arbiter
    import and2_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int UNIT_LAT = DEF_UNIT_LAT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]    req_a,
    input  logic [NUM_REQ*DATA_W-1:0]    req_b,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [id_width(NUM_REQ)-1:0] rsp_id,
    output logic [DATA_W-1:0]            rsp_y,
    output logic [DATA_W-1:0]            unit_a,
    output logic [DATA_W-1:0]            unit_b,
    input  logic [DATA_W-1:0]            unit_y
);

    localparam int ID_W  = id_width(NUM_REQ);
    localparam int CNT_W = id_width(UNIT_LAT + 1);

    arb_state_e        state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   cur_id;
    logic [CNT_W-1:0]  cnt;
    logic [ID_W-1:0]   winner;
    logic              any_req;
    logic              grant;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;

    and2_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req    (req_valid),
        .ptr    (ptr),
        .winner (winner),
        .any    (any_req)
    );

    // Ready is only offered from IDLE and is masked while reset is held.
    assign grant = !rst && (state == IDLE) && any_req;

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        req_ready = '0;
        sel_a     = '0;
        sel_b     = '0;
        if (grant) begin
            req_ready[winner] = 1'b1;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                sel_a = req_a[i*DATA_W +: DATA_W];
                sel_b = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cur_id    <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_id    <= '0;
            unit_a    <= '0;
            unit_b    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        cur_id <= winner;
                        unit_a <= sel_a;
                        unit_b <= sel_b;
                        cnt    <= CNT_W'(UNIT_LAT);
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        rsp_y     <= unit_y;
                        rsp_id    <= cur_id;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr       <= (cur_id == ID_W'(NUM_REQ - 1)) ? '0 : cur_id + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_and2_arbiter.sv
// Directed bench for and2_arbiter: a table of single operations plus
// hand-written reset, backpressure, mid-op reset and fairness sequences.
module tb_and2_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int DATA_W   = 1;
    localparam int UNIT_LAT = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_valid;
    logic [3:0] req_ready;
    logic [3:0] req_a;
    logic [3:0] req_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_id;
    logic [0:0] rsp_y;
    logic [0:0] unit_a;
    logic [0:0] unit_b;
    logic [0:0] unit_y;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] exp_ready;
        int         exp_id;
        logic       exp_y;
    } vec_t;

    vec_t vecs[9];

    int exp_order[6] = '{0, 1, 2, 3, 0, 1};
    int exp_fair_y[6] = '{1, 0, 1, 0, 1, 0};
    int grants[6];
    int rsp_ids[6];
    int rsp_ys[6];
    int rsp_cyc[6];

    always #5 clk = ~clk;

    // Registered and2 unit with one cycle of latency.
    always_ff @(posedge clk) begin
        unit_y <= unit_a & unit_b;
    end

    and2_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (DATA_W),
        .UNIT_LAT (UNIT_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .unit_a    (unit_a),
        .unit_b    (unit_b),
        .unit_y    (unit_y)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int onehot_idx(input logic [3:0] v);
        int r = -1;
        for (int i = 0; i < 4; i++) begin
            if (v[i] && r < 0) r = i;
        end
        return r;
    endfunction

    // Waits up to 10 edges for rsp_valid; returns edges taken.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 10) begin
            step();
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int lat;
        req_valid = v.valid;
        req_a     = v.a;
        req_b     = v.b;
        rsp_ready = 1'b1;
        #1;
        check($sformatf("v%0d req_ready", n), 32'(req_ready), 32'(v.exp_ready));
        step();
        req_valid = '0;
        check($sformatf("v%0d unit_a", n), 32'(unit_a), 32'(v.a[v.exp_id]));
        check($sformatf("v%0d unit_b", n), 32'(unit_b), 32'(v.b[v.exp_id]));
        wait_rsp(lat);
        check($sformatf("v%0d latency", n), 32'(lat), 32'(UNIT_LAT + 1));
        check($sformatf("v%0d rsp_id", n), 32'(rsp_id), 32'(v.exp_id));
        check($sformatf("v%0d rsp_y", n), 32'(rsp_y), 32'(v.exp_y));
        step();
        check($sformatf("v%0d rsp_valid_clr", n), 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int ngrant;
        int nrsp;

        //            valid    a        b        ready    id y
        vecs[0] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 2, 1'b1};
        vecs[1] = '{4'b0100, 4'b0100, 4'b0000, 4'b0100, 2, 1'b0};
        vecs[2] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 3, 1'b1};
        vecs[3] = '{4'b1010, 4'b1010, 4'b0010, 4'b0010, 1, 1'b1};
        vecs[4] = '{4'b1010, 4'b1010, 4'b0010, 4'b1000, 3, 1'b0};
        vecs[5] = '{4'b1010, 4'b0000, 4'b1111, 4'b0010, 1, 1'b0};
        vecs[6] = '{4'b1111, 4'b1111, 4'b1111, 4'b0100, 2, 1'b1};
        vecs[7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 0, 1'b1};
        vecs[8] = '{4'b0011, 4'b0001, 4'b0011, 4'b0010, 1, 1'b0};

        // Reset held with every requester asking.
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_a     = 4'b1111;
        req_b     = 4'b1111;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rst%0d req_ready", i), 32'(req_ready), 32'd0);
            check($sformatf("rst%0d rsp_valid", i), 32'(rsp_valid), 32'd0);
            check($sformatf("rst%0d unit_a", i), 32'(unit_a), 32'd0);
            check($sformatf("rst%0d unit_b", i), 32'(unit_b), 32'd0);
        end
        rst       = 1'b0;
        req_valid = '0;

        for (int n = 0; n < 9; n++) begin
            run_vec(vecs[n], n);
        end

        // Backpressure: ptr is 2, only requester 0 asks.
        req_valid = 4'b0001;
        req_a     = 4'b0001;
        req_b     = 4'b0001;
        rsp_ready = 1'b0;
        #1;
        check("bp req_ready", 32'(req_ready), 32'b0001);
        step();
        req_valid = 4'b1111;
        req_a     = 4'b0000;
        req_b     = 4'b0000;
        wait_rsp(lat);
        check("bp latency", 32'(lat), 32'(UNIT_LAT + 1));
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
            check($sformatf("bp%0d rsp_y", i), 32'(rsp_y), 32'd1);
            check($sformatf("bp%0d rsp_id", i), 32'(rsp_id), 32'd0);
            check($sformatf("bp%0d req_ready", i), 32'(req_ready), 32'd0);
            check($sformatf("bp%0d unit_a", i), 32'(unit_a), 32'd1);
            step();
        end
        rsp_ready = 1'b1;
        step();
        check("bp release rsp_valid", 32'(rsp_valid), 32'd0);
        check("bp release req_ready", 32'(req_ready), 32'b0010);
        req_a = 4'b1111;
        req_b = 4'b1111;
        step();
        check("midop unit_a", 32'(unit_a), 32'd1);
        check("midop unit_b", 32'(unit_b), 32'd1);

        // Reset while the accepted operation is in WAIT.
        rst       = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
        check("midop rst unit_a", 32'(unit_a), 32'd0);
        check("midop rst unit_b", 32'(unit_b), 32'd0);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("midop%0d rsp_valid", i), 32'(rsp_valid), 32'd0);
            step();
        end

        // Fairness from ptr=0 with every requester asking continuously.
        req_valid = 4'b1111;
        req_a     = 4'b1111;
        req_b     = 4'b0101;
        rsp_ready = 1'b1;
        ngrant    = 0;
        nrsp      = 0;
        for (int cyc = 0; cyc < 60 && nrsp < 6; cyc++) begin
            #1;
            check($sformatf("fair c%0d onehot", cyc), 32'($onehot0(req_ready)), 32'd1);
            if (req_ready != 4'b0000 && ngrant < 6) begin
                grants[ngrant] = onehot_idx(req_ready);
                ngrant++;
            end
            if (rsp_valid && rsp_ready) begin
                rsp_ids[nrsp] = int'(rsp_id);
                rsp_ys[nrsp]  = int'(rsp_y);
                rsp_cyc[nrsp] = cyc;
                nrsp++;
            end
            step();
        end
        check("fair responses", 32'(nrsp), 32'd6);
        check("fair grants", 32'(ngrant), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < ngrant) check($sformatf("fair grant%0d", i), 32'(grants[i]), 32'(exp_order[i]));
            if (i < nrsp) begin
                check($sformatf("fair rsp_id%0d", i), 32'(rsp_ids[i]), 32'(exp_order[i]));
                check($sformatf("fair rsp_y%0d", i), 32'(rsp_ys[i]), 32'(exp_fair_y[i]));
            end
            if (i > 0 && i < nrsp) begin
                check($sformatf("fair period%0d", i), 32'(rsp_cyc[i] - rsp_cyc[i-1]), 32'(UNIT_LAT + 3));
            end
        end
        req_valid = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
